demux8_slots: RTL and testbench
===============================

// Module: demux8_slots
// PURPOSE
//   Registered 1-to-8 distributor: the write-side counterpart of the 8:1 result mux.
//   Takes one DATA_W word plus a 3-bit destination select per handshake and parks it
//   in one of 8 holding slots. Each slot is cleared by its consumer through a per-slot ack.
//   Sits between the pipeline result producer and the eight consumers that feed the
//   8:1 select mux.
// PARAMETERS
//   DATA_W   32  width of each data word and each slot
//   STALL_W  16  width of the saturating stall counter
// PORTS
//   clk         in   1         clock; all state updates on rising edge
//   rst         in   1         synchronous, active-high reset
//   in_data     in   DATA_W    word to store
//   in_sel      in   3         destination slot index 0..7
//   in_valid    in   1         producer offers in_data/in_sel this cycle
//   in_ready    out  1         slot can accept; transfer occurs when in_valid & in_ready
//   slot_ack    in   8         bit i: consumer i takes slot i this cycle
//   slot_valid  out  8         bit i: slot i holds unconsumed data
//   slot_data   out  8*DATA_W  slot i at [DATA_W*i +: DATA_W]
//   occ_count   out  4         number of set bits in slot_valid (0..8)
//   stall_cnt   out  STALL_W   cycles with in_valid & !in_ready; saturates at all-ones
// BEHAVIOUR
//   Reset (rst=1 at an edge): slot_valid=0, slot_data=0, occ_count=0, stall_cnt=0.
//     in_ready reads 1 in the first cycle after reset. rst overrides every other input,
//     including a transfer or ack in the same cycle.
//   in_ready = !slot_valid[in_sel] | slot_ack[in_sel]. Combinational; no dependence on in_valid.
//   Write: on in_valid & in_ready, slot_data[in_sel] <= in_data and slot_valid[in_sel] <= 1.
//     Both values are visible in the next cycle, so latency is 1 cycle.
//   Ack: slot_ack[i] & slot_valid[i] clears slot_valid[i] at the edge.
//     slot_data[i] keeps its old value.
//     slot_ack[i] with slot_valid[i]=0 is ignored; no error is raised.
//   Simultaneous ack and write to the same slot: the write wins.
//     The slot stays valid with the new data and occ_count is unchanged.
//   Acks to other slots in the same cycle as a write are all honoured independently.
//   No transfer while in_valid=0: in_sel/in_data are don't-care and state is unchanged
//     apart from acks.
//   occ_count is registered. It is updated at the same edge as slot_valid and always
//     equals popcount(slot_valid).
//   stall_cnt increments on each edge where in_valid & !in_ready. It holds at
//     2^STALL_W-1 and is cleared only by rst.
//   Producer rule: in_data/in_sel must stay stable while in_valid=1 and in_ready=0.
//     The block does not check this.
//   No FSM beyond the per-slot valid bits. The slots are independent; there is no
//     ordering between them.
// TESTING
//   T1 reset: assert rst for 2 cycles mid-traffic with slots 1,5 valid
//      -> slot_valid=0, occ_count=0, stall_cnt=0, in_ready=1.
//   T2 fill: write 0xA0000000+i to sel=i for i=0..7 back-to-back
//      -> one transfer per cycle; slot_valid=0xFF and occ_count=8 one cycle after the last write.
//   T3 block: with slot 3 valid, hold in_valid=1, sel=3 for 5 cycles, no ack
//      -> in_ready=0 and stall_cnt=5; ack slot 3 -> the write lands that edge and slot 3
//      holds the new word.
//   T4 same-cycle ack+write: slot 2 holds 0x11111111; write 0x22222222 to sel=2 with
//      slot_ack=0x04 -> slot_valid[2]=1, slot 2 = 0x22222222, occ_count unchanged.
//   T5 spurious ack: slot_ack=0xFF with slot_valid=0x00 -> no state change, occ_count=0.
//   T6 saturation (STALL_W=4): 20 stall cycles -> stall_cnt=15 and held there.

Source files
------------

// File: rtl/demux8_slots_if.sv
// Producer/consumer bundle for the 1-to-8 slot distributor.
// Handshake: a word moves when in_valid & in_ready at a rising edge; in_ready never looks at in_valid.
interface demux8_slots_if #(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 16
);
  logic [DATA_W-1:0]   in_data;
  logic [2:0]          in_sel;
  logic                in_valid;
  logic                in_ready;
  logic [7:0]          slot_ack;
  logic [7:0]          slot_valid;
  logic [8*DATA_W-1:0] slot_data;
  logic [3:0]          occ_count;
  logic [STALL_W-1:0]  stall_cnt;

  modport master (
    output in_data, in_sel, in_valid, slot_ack,
    input  in_ready, slot_valid, slot_data, occ_count, stall_cnt
  );

  modport slave (
    input  in_data, in_sel, in_valid, slot_ack,
    output in_ready, slot_valid, slot_data, occ_count, stall_cnt
  );
endinterface

// File: rtl/demux8_slots.sv
// Registered 1-to-8 distributor: parks each accepted word in the slot named by in_sel
// until that slot's consumer acks it. Slots are independent per-slot valid bits, no FSM.
module demux8_slots #(
  parameter int DATA_W  = 32,
  parameter int STALL_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  demux8_slots_if.slave bus
);
  logic [7:0]         valid_q;
  logic [7:0]         valid_d;
  logic [DATA_W-1:0]  data_q [8];
  logic [3:0]         occ_q;
  logic [3:0]         occ_d;
  logic [STALL_W-1:0] stall_q;
  logic               ready;
  logic               wr;
  logic               stall;

  // A slot being acked this cycle frees itself in time for a same-edge write.
  assign ready = !valid_q[bus.in_sel] | bus.slot_ack[bus.in_sel];
  assign wr    = bus.in_valid & ready;
  assign stall = bus.in_valid & !ready;

  always_comb begin
    valid_d = valid_q & ~bus.slot_ack;
    if (wr) valid_d[bus.in_sel] = 1'b1;
  end

  always_comb begin
    occ_d = 4'd0;
    for (int i = 0; i < 8; i++) occ_d = occ_d + {3'd0, valid_d[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 8'd0;
      occ_q   <= 4'd0;
      stall_q <= '0;
      for (int i = 0; i < 8; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      if (wr) data_q[bus.in_sel] <= bus.in_data;
      if (stall && (stall_q != {STALL_W{1'b1}})) stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.slot_valid = valid_q;
  assign bus.occ_count  = occ_q;
  assign bus.stall_cnt  = stall_q;

  for (genvar g = 0; g < 8; g++) begin : g_slot
    assign bus.slot_data[DATA_W*g +: DATA_W] = data_q[g];
  end
endmodule

// File: tb/tb_demux8_slots.sv
// Directed bench for demux8_slots: reset, fill, blocking, ack+write collision,
// spurious acks and stall-counter saturation (STALL_W=4).
module tb_demux8_slots;
  localparam int DATA_W  = 32;
  localparam int STALL_W = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [DATA_W-1:0] exp_q[$];

  demux8_slots_if #(.DATA_W(DATA_W), .STALL_W(STALL_W)) bus ();

  demux8_slots #(.DATA_W(DATA_W), .STALL_W(STALL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] slot(input int i);
    return bus.slot_data[DATA_W*i +: DATA_W];
  endfunction

  // drivers: inputs change at the falling edge, outputs are sampled there too
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] sel, input logic [DATA_W-1:0] d,
                       input logic [7:0] ack);
    bus.in_valid = v;
    bus.in_sel   = sel;
    bus.in_data  = d;
    bus.slot_ack = ack;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, '0, 8'h00);
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    int exp_stall;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    idle();
    @(negedge clk);
    step();
    rst = 1'b0;
    #1;
    check("rst_valid", bus.slot_valid, 8'h00);
    check("rst_occ", bus.occ_count, 4'd0);
    check("rst_stall", bus.stall_cnt, 4'd0);
    check("rst_ready", bus.in_ready, 1'b1);

    // T1: reset mid-traffic with slots 1 and 5 valid and a stall pending
    drive(1'b1, 3'd1, 32'h0000_0001, 8'h00); step();
    drive(1'b1, 3'd5, 32'h0000_0005, 8'h00); step();
    drive(1'b1, 3'd1, 32'h0000_0011, 8'h00); step();
    check("t1_pre_valid", bus.slot_valid, 8'h22);
    check("t1_pre_stall", bus.stall_cnt, 4'd1);
    rst = 1'b1;
    drive(1'b1, 3'd1, 32'h0000_0011, 8'h00); step(); step();
    rst = 1'b0;
    idle();
    check("t1_valid", bus.slot_valid, 8'h00);
    check("t1_occ", bus.occ_count, 4'd0);
    check("t1_stall", bus.stall_cnt, 4'd0);
    check("t1_ready", bus.in_ready, 1'b1);
    check("t1_data1", slot(1), 32'h0);

    // T2: fill all eight slots back-to-back
    for (int i = 0; i < 8; i++) begin
      w = 32'hA000_0000 + DATA_W'(i);
      exp_q.push_back(w);
      drive(1'b1, 3'(i), w, 8'h00);
      check($sformatf("t2_ready%0d", i), bus.in_ready, 1'b1);
      step();
    end
    idle();
    check("t2_valid", bus.slot_valid, 8'hFF);
    check("t2_occ", bus.occ_count, 4'd8);
    for (int i = 0; i < 8; i++) check($sformatf("t2_data%0d", i), slot(i), exp_q.pop_front());
    check("t2_stall", bus.stall_cnt, 4'd0);

    // T3: blocked on slot 3 for five cycles, then released by its ack
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 3'd3, 32'h3333_3333, 8'h00);
      check($sformatf("t3_block%0d", k), bus.in_ready, 1'b0);
      step();
    end
    check("t3_stall", bus.stall_cnt, 4'd5);
    check("t3_hold", slot(3), 32'hA000_0003);
    drive(1'b1, 3'd3, 32'h3333_3333, 8'h08);
    check("t3_ready_ack", bus.in_ready, 1'b1);
    step();
    idle();
    check("t3_data", slot(3), 32'h3333_3333);
    check("t3_valid", bus.slot_valid, 8'hFF);
    check("t3_occ", bus.occ_count, 4'd8);
    check("t3_stall_hold", bus.stall_cnt, 4'd5);
    drive(1'b0, 3'd0, '0, 8'hFF); step(); idle();
    check("t3_drain_valid", bus.slot_valid, 8'h00);
    check("t3_drain_occ", bus.occ_count, 4'd0);
    check("t3_drain_data", slot(0), 32'hA000_0000);

    // T4: ack+write to slot 2 in the same cycle, plus an independent ack of slot 6
    drive(1'b1, 3'd2, 32'h1111_1111, 8'h00); step();
    drive(1'b1, 3'd6, 32'h6666_6666, 8'h00); step();
    idle();
    check("t4_pre_occ", bus.occ_count, 4'd2);
    drive(1'b1, 3'd2, 32'h2222_2222, 8'h44);
    check("t4_ready", bus.in_ready, 1'b1);
    step();
    idle();
    check("t4_valid", bus.slot_valid, 8'h04);
    check("t4_data", slot(2), 32'h2222_2222);
    check("t4_occ", bus.occ_count, 4'd1);
    check("t4_data6", slot(6), 32'h6666_6666);

    // T5: spurious acks on empty slots change nothing
    drive(1'b0, 3'd0, '0, 8'h04); step(); idle();
    check("t5_clear", bus.slot_valid, 8'h00);
    drive(1'b0, 3'd0, '0, 8'hFF); step(); idle();
    check("t5_valid", bus.slot_valid, 8'h00);
    check("t5_occ", bus.occ_count, 4'd0);
    check("t5_data2", slot(2), 32'h2222_2222);
    check("t5_stall", bus.stall_cnt, 4'd5);

    // T6: 20 stall cycles saturate the 4-bit counter at 15
    drive(1'b1, 3'd0, 32'hC0C0_C0C0, 8'h00); step();
    exp_stall = 5;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 3'd0, 32'hDEAD_BEEF, 8'h00);
      step();
      if (exp_stall < 15) exp_stall++;
      if (k == 8 || k == 9 || k == 19)
        check($sformatf("t6_stall%0d", k), bus.stall_cnt, 64'(exp_stall));
    end
    idle();
    check("t6_data", slot(0), 32'hC0C0_C0C0);
    check("t6_occ", bus.occ_count, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
